// File: rtl/fifo_uart_framer_pkg.sv
// Shared types and constants for the sniffer FIFO-to-UART framer.
// Width helpers let the top size its counters from its own parameter overrides.
package fifo_uart_framer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SEND_SOF,
    S_SEND_SEQ,
    S_SEND_LEN,
    S_SEND_PAY,
    S_SEND_CHK
  } state_t;

  localparam logic [7:0]  SOF_DEFAULT         = 8'hA5;
  localparam int unsigned MAX_PAYLOAD_DEFAULT = 16;
  localparam int unsigned TIMEOUT_DEFAULT     = 1200;

  function automatic int unsigned cnt_w(input int unsigned max_payload);
    return $clog2(max_payload + 1);
  endfunction

  function automatic int unsigned to_w(input int unsigned timeout);
    return $clog2(timeout);
  endfunction

  localparam int unsigned CNT_W = cnt_w(MAX_PAYLOAD_DEFAULT);
  localparam int unsigned TO_W  = to_w(TIMEOUT_DEFAULT);

endpackage

// File: rtl/fifo_frame_buf.sv
// Payload buffer for one frame: single write port, combinational indexed read.
module fifo_frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] count,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[count] <= wdata;
  end

  assign rdata = r_mem[rd_idx];

endmodule

// File: rtl/fifo_uart_framer.sv
// Drains the sniffer FIFO into a local buffer and emits SOF/SEQ/LEN/payload/CHK
// frames to a byte-wide UART transmitter on buffer full or idle timeout.
module fifo_uart_framer
  import fifo_uart_framer_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = MAX_PAYLOAD_DEFAULT,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEFAULT,
  parameter logic [7:0]  SOF_BYTE    = SOF_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_rd_DATA,
  input  logic       fifo_rd_empty,
  output logic [7:0] tx_DATA,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       frame_active,
  output logic [7:0] seq
);

  localparam int unsigned CNT_BITS = cnt_w(MAX_PAYLOAD);
  localparam int unsigned TO_BITS  = to_w(TIMEOUT);
  localparam int unsigned IDX_BITS = $clog2(MAX_PAYLOAD);
  localparam logic [CNT_BITS-1:0] C_MAX     = CNT_BITS'(MAX_PAYLOAD);
  localparam logic [CNT_BITS-1:0] C_MAX_M1  = CNT_BITS'(MAX_PAYLOAD - 1);
  localparam logic [TO_BITS-1:0]  C_TO_LAST = TO_BITS'(TIMEOUT - 1);

  state_t              r_state, w_state_nx;
  logic [CNT_BITS-1:0] r_count;
  logic [TO_BITS-1:0]  r_to;
  logic [IDX_BITS-1:0] r_idx;
  logic [7:0]          r_chk, r_seq, r_tx_data;
  logic                r_rd_pend, r_tx_start, r_frame_active;
  logic                w_rd, w_exit, w_issue, w_last_pay;
  logic [7:0]          w_byte, w_rdata;

  // The capture that fills the buffer exits FILL in the same edge, so SOF
  // follows the last capture by two cycles.
  assign w_exit = (r_state == S_FILL) &&
                  ((r_count == C_MAX) ||
                   (r_rd_pend && r_count == C_MAX_M1) ||
                   (r_count != '0 && !r_rd_pend && r_to == C_TO_LAST));
  assign w_rd = (r_state == S_FILL) && !fifo_rd_empty && !r_rd_pend &&
                (r_count < C_MAX) && !w_exit;
  assign w_last_pay = (CNT_BITS'(r_idx) + CNT_BITS'(1)) == r_count;

  fifo_frame_buf #(.DEPTH(MAX_PAYLOAD), .IDX_W(IDX_BITS)) u_buf (
    .clk    (clk),
    .we     (r_rd_pend),
    .wdata  (fifo_rd_DATA),
    .count  (r_count[IDX_BITS-1:0]),
    .rd_idx (r_idx),
    .rdata  (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_byte     = '0;
    w_issue    = 1'b0;
    case (r_state)
      S_IDLE: if (en) w_state_nx = S_FILL;
      S_FILL: if (w_exit) w_state_nx = S_SEND_SOF;
      S_SEND_SOF: begin
        w_byte  = SOF_BYTE;
        w_issue = !tx_busy && !r_tx_start;
        if (r_tx_start) w_state_nx = S_SEND_SEQ;
      end
      S_SEND_SEQ: begin
        w_byte  = r_seq;
        w_issue = !tx_busy && !r_tx_start;
        if (r_tx_start) w_state_nx = S_SEND_LEN;
      end
      S_SEND_LEN: begin
        w_byte  = 8'(r_count);
        w_issue = !tx_busy && !r_tx_start;
        if (r_tx_start) w_state_nx = S_SEND_PAY;
      end
      S_SEND_PAY: begin
        w_byte  = w_rdata;
        w_issue = !tx_busy && !r_tx_start;
        if (r_tx_start && w_last_pay) w_state_nx = S_SEND_CHK;
      end
      S_SEND_CHK: begin
        w_byte  = r_chk;
        w_issue = !tx_busy && !r_tx_start;
        if (r_tx_start) w_state_nx = en ? S_FILL : S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count        <= '0;
      r_to           <= '0;
      r_idx          <= '0;
      r_chk          <= '0;
      r_seq          <= '0;
      r_tx_data      <= '0;
      r_rd_pend      <= 1'b0;
      r_tx_start     <= 1'b0;
      r_frame_active <= 1'b0;
    end else begin
      r_rd_pend  <= w_rd;
      r_tx_start <= w_issue;
      if (r_state != S_FILL || r_rd_pend || r_count == '0) r_to <= '0;
      else if (r_to != C_TO_LAST)                          r_to <= r_to + 1'b1;
      if (r_rd_pend) r_count <= r_count + 1'b1;
      if (w_issue) begin
        r_tx_data <= w_byte;
        if (r_state == S_SEND_SOF)      r_frame_active <= 1'b1;
        else if (r_state != S_SEND_CHK) r_chk <= r_chk ^ w_byte;
      end
      if (r_tx_start && r_state == S_SEND_PAY) r_idx <= r_idx + 1'b1;
      if (r_tx_start && r_state == S_SEND_CHK) begin
        r_seq          <= r_seq + 1'b1;
        r_count        <= '0;
        r_idx          <= '0;
        r_chk          <= '0;
        r_frame_active <= 1'b0;
      end
    end
  end

  assign fifo_rd_en   = w_rd;
  assign tx_DATA      = r_tx_data;
  assign tx_start     = r_tx_start;
  assign frame_active = r_frame_active;
  assign seq          = r_seq;

endmodule

// File: tb/tb_fifo_uart_framer.sv
// Randomized bench for fifo_uart_framer: FIFO and UART models plus a
// frame-level reference that chunks the byte stream into checksummed frames.
module tb_fifo_uart_framer;

  localparam int unsigned MAXP = 16;
  localparam int unsigned TOUT = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_DATA = '0;
  logic       fifo_rd_empty = 1'b1;
  logic [7:0] tx_DATA;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic       frame_active;
  logic [7:0] seq;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int busy_left = 0;
  bit force_busy = 1'b0;
  int busy_viol = 0;
  int empty_viol = 0;
  int fa_viol = 0;
  logic [7:0] exp_seq = '0;

  logic [7:0] fifo_q[$];
  logic [7:0] burst_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  int         tx_cyc[$];
  int         rd_cyc[$];

  always #5 clk = ~clk;

  fifo_uart_framer #(.MAX_PAYLOAD(MAXP), .TIMEOUT(TOUT), .SOF_BYTE(8'hA5)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_DATA  (fifo_rd_DATA),
    .fifo_rd_empty (fifo_rd_empty),
    .tx_DATA       (tx_DATA),
    .tx_start      (tx_start),
    .tx_busy       (tx_busy),
    .frame_active  (frame_active),
    .seq           (seq)
  );

  // FIFO (data one cycle after rd_en) and UART (busy 10 cycles per byte)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && fifo_q.size() != 0) fifo_rd_DATA <= fifo_q.pop_front();
    fifo_rd_empty <= (fifo_q.size() == 0);
    if (tx_start) busy_left = 10;
    else if (busy_left > 0) busy_left = busy_left - 1;
    tx_busy <= force_busy || (busy_left > 0);
  end

  always @(negedge clk) begin
    if (tx_start) begin
      tx_q.push_back(tx_DATA);
      tx_cyc.push_back(cyc);
      if (tx_busy) busy_viol++;
      if (!frame_active) fa_viol++;
    end
    if (fifo_rd_en) begin
      rd_cyc.push_back(cyc);
      if (fifo_rd_empty) empty_viol++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    burst_q.push_back(b);
  endtask

  // Reference: split the pushed stream into MAXP-sized frames
  task automatic model_chunks();
    logic [7:0] len, chk, b;
    while (burst_q.size() > 0) begin
      len = (burst_q.size() > MAXP) ? 8'(MAXP) : 8'(burst_q.size());
      chk = exp_seq ^ len;
      exp_q.push_back(8'hA5);
      exp_q.push_back(exp_seq);
      exp_q.push_back(len);
      repeat (int'(len)) begin
        b = burst_q.pop_front();
        exp_q.push_back(b);
        chk = chk ^ b;
      end
      exp_q.push_back(chk);
      exp_seq = exp_seq + 8'd1;
    end
  endtask

  task automatic wait_tx(input int n, input int budget, output bit ok);
    int i = 0;
    while (tx_q.size() < n && i < budget) begin
      step(1);
      i++;
    end
    ok = (tx_q.size() >= n);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    force_busy = 1'b0;
    fifo_q.delete();
    burst_q.delete();
    exp_q.delete();
    step(3);
    tx_q.delete();
    tx_cyc.delete();
    rd_cyc.delete();
    exp_seq = '0;
    rst = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en  = 1'b1;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    step(3);
    vectors++; if (fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL rst_rd_en got=%b want=0", fifo_rd_en); end
    vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL rst_tx_start got=%b want=0", tx_start); end
    vectors++; if (frame_active !== 1'b0) begin miscompares++; $display("FAIL rst_frame_active got=%b want=0", frame_active); end
    vectors++; if (tx_DATA !== 8'h00) begin miscompares++; $display("FAIL rst_tx_data got=%h want=00", tx_DATA); end
    vectors++; if (seq !== 8'h00) begin miscompares++; $display("FAIL rst_seq got=%h want=00", seq); end
    en  = 1'b0;
    rst = 1'b1;
    step(6);
    vectors++; if (rd_cyc.size() != 0) begin miscompares++; $display("FAIL idle_no_read got=%0d want=0", rd_cyc.size()); end
  endtask

  task automatic test_small_frame();
    bit ok;
    logic [7:0] got;
    int lat;
    model_chunks();
    en = 1'b1;
    wait_tx(exp_q.size(), 600, ok);
    step(40);
    vectors++; if (!ok || tx_q.size() != exp_q.size()) begin miscompares++; $display("FAIL small_len got=%0d want=%0d", tx_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL small_byte[%0d] got=%h want=%h", i, got, exp_q[i]); end
    end
    vectors++; if (rd_cyc.size() != 3) begin miscompares++; $display("FAIL small_rd_pulses got=%0d want=3", rd_cyc.size()); end
    lat = (rd_cyc.size() >= 3 && tx_cyc.size() > 0) ? tx_cyc[0] - (rd_cyc[2] + 1) : -1;
    vectors++; if (lat < int'(TOUT) + 2 || lat > int'(TOUT) + 3) begin miscompares++; $display("FAIL small_sof_latency got=%0d want=%0d..%0d", lat, TOUT + 2, TOUT + 3); end
    vectors++; if (frame_active !== 1'b0) begin miscompares++; $display("FAIL small_frame_active got=%b want=0", frame_active); end
    vectors++; if (seq !== exp_seq) begin miscompares++; $display("FAIL small_seq got=%h want=%h", seq, exp_seq); end
    tx_q.delete(); tx_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_full_frame();
    bit ok;
    logic [7:0] got;
    int lat;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 20; i++) push_byte(8'(i));
    model_chunks();
    wait_tx(exp_q.size(), 1500, ok);
    step(20);
    vectors++; if (!ok || tx_q.size() != exp_q.size()) begin miscompares++; $display("FAIL full_len got=%0d want=%0d", tx_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL full_byte[%0d] got=%h want=%h", i, got, exp_q[i]); end
    end
    got = (tx_q.size() > 27) ? tx_q[27] : 8'hxx;
    vectors++; if (got !== 8'h05) begin miscompares++; $display("FAIL full_chk2 got=%h want=05", got); end
    vectors++; if (rd_cyc.size() != 20) begin miscompares++; $display("FAIL full_rd_pulses got=%0d want=20", rd_cyc.size()); end
    lat = (rd_cyc.size() >= 16 && tx_cyc.size() > 0) ? tx_cyc[0] - (rd_cyc[15] + 1) : -1;
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL full_sof_latency got=%0d want=2", lat); end
    tx_q.delete(); tx_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_busy_hold();
    bit ok;
    logic [7:0] got;
    int hold_bad = 0;
    push_byte(8'($urandom));
    model_chunks();
    wait_tx(1, 300, ok);
    force_busy = 1'b1;
    for (int i = 0; i < 500; i++) begin
      step(1);
      if (tx_DATA !== 8'hA5) hold_bad++;
    end
    vectors++; if (!ok || tx_q.size() != 1) begin miscompares++; $display("FAIL busy_starts got=%0d want=1", tx_q.size()); end
    vectors++; if (hold_bad != 0) begin miscompares++; $display("FAIL busy_hold_data got=%0d bad cycles want=0", hold_bad); end
    force_busy = 1'b0;
    wait_tx(exp_q.size(), 400, ok);
    step(20);
    vectors++; if (!ok || tx_q.size() != exp_q.size()) begin miscompares++; $display("FAIL busy_len got=%0d want=%0d", tx_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL busy_byte[%0d] got=%h want=%h", i, got, exp_q[i]); end
    end
    vectors++; if (busy_viol != 0) begin miscompares++; $display("FAIL busy_start_while_busy got=%0d want=0", busy_viol); end
    tx_q.delete(); tx_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] got;
    for (int i = 0; i < 10; i++) push_byte(8'($urandom));
    burst_q.delete();
    wait_tx(5, 400, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rmid_reach_pay got=%0d want=5", tx_q.size()); end
    rst = 1'b0;
    #1;
    vectors++; if (tx_start !== 1'b0 || frame_active !== 1'b0 || fifo_rd_en !== 1'b0) begin
      miscompares++; $display("FAIL rmid_ctrl got=%b%b%b want=000", tx_start, frame_active, fifo_rd_en);
    end
    vectors++; if (tx_DATA !== 8'h00 || seq !== 8'h00) begin miscompares++; $display("FAIL rmid_data_seq got=%h/%h want=00/00", tx_DATA, seq); end
    fifo_q.delete();
    step(3);
    tx_q.delete(); tx_cyc.delete(); exp_q.delete();
    exp_seq = '0;
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    model_chunks();
    en  = 1'b1;
    rst = 1'b1;
    wait_tx(exp_q.size(), 400, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rmid_len got=%0d want=%0d", tx_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL rmid_byte[%0d] got=%h want=%h", i, got, exp_q[i]); end
    end
    tx_q.delete(); tx_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_en_drop();
    bit ok;
    logic [7:0] got;
    int rd_before;
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    model_chunks();
    wait_tx(2, 400, ok);
    en = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'($urandom));
    wait_tx(exp_q.size(), 400, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL endrop_len got=%0d want=%0d", tx_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL endrop_byte[%0d] got=%h want=%h", i, got, exp_q[i]); end
    end
    tx_q.delete(); tx_cyc.delete(); exp_q.delete();
    rd_before = rd_cyc.size();
    step(100);
    vectors++; if (rd_cyc.size() != rd_before) begin miscompares++; $display("FAIL endrop_idle_reads got=%0d want=0", rd_cyc.size() - rd_before); end
    vectors++; if (tx_q.size() != 0 || frame_active !== 1'b0) begin miscompares++; $display("FAIL endrop_idle_tx got=%0d/%b want=0/0", tx_q.size(), frame_active); end
    model_chunks();
    en = 1'b1;
    wait_tx(exp_q.size(), 400, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL resume_len got=%0d want=%0d", tx_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL resume_byte[%0d] got=%h want=%h", i, got, exp_q[i]); end
    end
    tx_q.delete(); tx_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] got;
    int n;
    for (int r = 0; r < 4; r++) begin
      rd_cyc.delete();
      n = $urandom_range(40, 1);
      for (int i = 0; i < n; i++) push_byte(8'($urandom));
      model_chunks();
      wait_tx(exp_q.size(), 3000, ok);
      step(10);
      vectors++; if (!ok || tx_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rand%0d_len got=%0d want=%0d", r, tx_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
        vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL rand%0d_byte[%0d] got=%h want=%h", r, i, got, exp_q[i]); end
      end
      vectors++; if (rd_cyc.size() != n) begin miscompares++; $display("FAIL rand%0d_rd_pulses got=%0d want=%0d", r, rd_cyc.size(), n); end
      tx_q.delete(); tx_cyc.delete(); exp_q.delete();
    end
    vectors++; if (empty_viol != 0 || fa_viol != 0) begin miscompares++; $display("FAIL rand_protocol got=%0d/%0d want=0/0", empty_viol, fa_viol); end
  endtask

  task automatic test_seq_wrap();
    bit ok;
    logic [7:0] got;
    do_reset();
    en = 1'b1;
    for (int f = 0; f < 257; f++) begin
      push_byte(8'($urandom));
      model_chunks();
      wait_tx(exp_q.size(), 300, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL wrap%0d_len got=%0d want=%0d", f, tx_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
        vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL wrap%0d_byte[%0d] got=%h want=%h", f, i, got, exp_q[i]); end
      end
      tx_q.delete(); tx_cyc.delete(); exp_q.delete();
    end
    step(2);
    vectors++; if (seq !== 8'h01) begin miscompares++; $display("FAIL wrap_final_seq got=%h want=01", seq); end
  endtask

  initial begin
    test_reset();
    test_small_frame();
    test_full_frame();
    test_busy_hold();
    test_reset_mid();
    test_en_drop();
    test_random();
    test_seq_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
